// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit.
// Op codes, FSM state encoding and default latencies.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  function automatic logic is_mul(
    input logic [2:0] op
  );
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(
    input logic [2:0] op
  );
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result datapath for the multiply-divide unit.
// Produces {hi,lo} for the latched op and flags a zero divisor.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);

  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic               sovf;

  assign sa    = $signed(a);
  assign sb    = $signed(b);
  assign sa64  = {{32{a[31]}}, a};
  assign sb64  = {{32{b[31]}}, b};
  assign sprod = sa64 * sb64;
  assign uprod = {32'd0, a} * {32'd0, b};
  assign sovf  = (a == 32'h8000_0000) &&
                 (b == 32'hFFFF_FFFF);

  // Select the result pair for the op; zero divisor yields no result
  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    div0   = 1'b0;
    case (op)
      OP_MULT: begin
        hi_res = sprod[63:32];
        lo_res = sprod[31:0];
      end
      OP_MULTU: begin
        hi_res = uprod[63:32];
        lo_res = uprod[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else if (sovf) begin
          // Most-negative / -1 wraps; avoid the undefined divide
          lo_res = 32'h8000_0000;
          hi_res = 32'd0;
        end else begin
          lo_res = sa / sb;
          hi_res = sa % sb;
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else begin
          lo_res = a / b;
          hi_res = a % b;
        end
      end
      default: begin
        hi_res = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide control: FSM, latency counter, HI/LO.
// Stalls the D stage while a HI/LO user waits on a result.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT =
    (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [31:0]   hi_res;
  logic [31:0]   lo_res;
  logic          div0;

  mdu_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  assign stall_md = d_is_md &
    (busy | (start & (is_mul(op) | is_div(op))));

  // Next-state: accept starts in IDLE, count down, commit at end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            state_d = ST_MUL;
            cnt_d   = CW'(MULT_LAT);
            op_d    = op;
            a_d     = a;
            b_d     = b;
          end
          OP_DIV, OP_DIVU: begin
            state_d = ST_DIV;
            cnt_d   = CW'(DIV_LAT);
            op_d    = op;
            a_d     = a;
            b_d     = b;
          end
          OP_MTHI: hi_d = a;
          OP_MTLO: lo_d = a;
          default: state_d = ST_IDLE;
        endcase
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q <= CW'(1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (!div0) begin
          hi_d = hi_res;
          lo_d = lo_res;
        end
      end
    end
  end

  // State registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with hand-computed results.
// Checks latency, HI/LO values, stall and reset behaviour.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests;
  int n_fail;

  mdu_ctrl #(
    .MULT_LAT (5),
    .DIV_LAT  (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, return number of busy cycles seen
  task automatic run_op(
    input  logic [2:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output int          n
  );
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
  endtask

  int n;
  int ns;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 3'd0;
    a       = 32'd0;
    b       = 32'd0;
    d_is_md = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    d_is_md = 1'b1;
    #1;
    check("rst_stall", 64'(stall_md), 64'd0);
    d_is_md = 1'b0;

    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, n);
    check("mult_lat", 64'(n), 64'd5);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFC, n);
    check("mult2_hi", 64'(hi), 64'd0);
    check("mult2_lo", 64'(lo), 64'd12);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
    check("div_lat", 64'(n), 64'd10);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);

    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, n);
    check("div2_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div2_hi", 64'(hi), 64'd1);

    run_op(OP_DIVU, 32'd100, 32'd7, n);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);

    run_op(OP_MTHI, 32'h11, 32'd0, n);
    check("mthi_busy", 64'(n), 64'd0);
    check("mthi_hi", 64'(hi), 64'h11);
    run_op(OP_MTLO, 32'h22, 32'd0, n);
    check("mtlo_lo", 64'(lo), 64'h22);
    check("mtlo_hi", 64'(hi), 64'h11);

    run_op(OP_DIVU, 32'd100, 32'd0, n);
    check("div0_lat", 64'(n), 64'd10);
    check("div0_hi", 64'(hi), 64'h11);
    check("div0_lo", 64'(lo), 64'h22);

    run_op(3'd6, 32'h99, 32'h5, n);
    check("nop_busy", 64'(n), 64'd0);
    check("nop_hi", 64'(hi), 64'h11);
    check("nop_lo", 64'(lo), 64'h22);

    d_is_md = 1'b1;
    start   = 1'b1;
    op      = OP_MULTU;
    a       = 32'hFFFF_FFFF;
    b       = 32'hFFFF_FFFF;
    #1;
    check("stall_start", 64'(stall_md), 64'd1);
    tick();
    start = 1'b0;
    n  = 0;
    ns = 0;
    while (busy && n < 50) begin
      n++;
      if (stall_md) ns++;
      tick();
    end
    check("multu_lat", 64'(n), 64'd5);
    check("stall_cyc", 64'(ns), 64'd5);
    check("stall_after", 64'(stall_md), 64'd0);
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0001);
    d_is_md = 1'b0;

    start = 1'b1;
    op    = OP_DIV;
    a     = 32'd100;
    b     = 32'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy4", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    for (int i = 0; i < 12; i++) tick();
    check("abort_late_hi", 64'(hi), 64'd0);
    check("abort_late_lo", 64'(lo), 64'd0);

    reset = 1'b1;
    start = 1'b1;
    op    = OP_MTHI;
    a     = 32'h5;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rst_prio_hi", 64'(hi), 64'd0);

    start = 1'b1;
    op    = OP_MULT;
    a     = 32'd2;
    b     = 32'd3;
    tick();
    op = OP_DIV;
    a  = 32'd100;
    b  = 32'd7;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    check("ign_lat", 64'(n), 64'd4);
    check("ign_hi", 64'(hi), 64'd0);
    check("ign_lo", 64'(lo), 64'd6);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 5, busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_LAT, default 10, busy cycles for DIV/DIVU.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  E-stage HI/LO-class instruction valid this cycle.
REQ-006 op  input  3  operation code from the shared package.
REQ-007 a  input  32  forwarded rs value (E stage).
REQ-008 b  input  32  forwarded rt value (E stage).
REQ-009 d_is_md  input  1  D-stage instruction reads or writes HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 busy  output  1  multi-cycle operation in progress.
REQ-011 stall_md  output  1  request to stall PC/ID and flush EX; ORed with the hazard unit's stall.
REQ-012 hi  output  32  architectural HI register.
REQ-013 lo  output  32  architectural LO register.

Function
REQ-014 The block SHALL support these ops: MULT, MULTU, DIV, DIVU, MTHI, MTLO. Any other op with start=1 SHALL be a no-op.
REQ-015 The FSM SHALL have three states: IDLE, MUL, DIV.
- IDLE to MUL on start with MULT/MULTU.
- IDLE to DIV on start with DIV/DIVU.
- MUL/DIV back to IDLE when the counter expires.
REQ-016 On a start edge, a and b SHALL be latched into operand registers, and the counter SHALL load MULT_LAT or DIV_LAT.
REQ-017 busy SHALL be 1 for exactly MULT_LAT (or DIV_LAT) consecutive cycles, beginning the cycle after start is sampled.
REQ-018 hi/lo SHALL update on the edge that ends the last busy cycle; the new values are visible in the first cycle with busy=0.
REQ-019 MULT results: {hi,lo} = signed 64-bit product. MULTU results: {hi,lo} = unsigned 64-bit product.
REQ-020 DIV results: lo = signed quotient, hi = signed remainder, truncating toward zero; the remainder takes the sign of the dividend.
REQ-021 DIVU results: lo = unsigned quotient, hi = unsigned remainder.
REQ-022 If the divisor is zero, DIV/DIVU SHALL still hold busy for DIV_LAT cycles, and hi/lo SHALL keep their old values.
REQ-023 MTHI/MTLO with start=1 in IDLE SHALL write a to hi/lo on the same edge; busy stays 0.
REQ-024 start while busy=1 SHALL be ignored: no state, operand or HI/LO change.
REQ-025 stall_md SHALL equal d_is_md AND (busy OR (start AND op is MULT/MULTU/DIV/DIVU)), combinationally.
REQ-026 When a stall is asserted, the stalled D-stage instruction SHALL proceed in the first cycle with busy=0, and mfhi/mflo SHALL read the new values.
REQ-027 hi and lo SHALL change only as specified in REQ-018, REQ-022 and REQ-023.

Reset
REQ-028 When reset=1 at a clock edge, the following SHALL hold after that edge:
- state = IDLE, counter = 0
- operand registers = 0
- hi = 0, lo = 0, busy = 0
REQ-029 reset during MUL/DIV SHALL abort the operation; no HI/LO commit occurs.
REQ-030 reset SHALL take priority over start on the same edge.
REQ-031 stall_md SHALL be 0 in the cycle after reset, unless start AND d_is_md are asserted in that cycle.

Structure
REQ-032 Package mdu_pkg SHALL hold:
- op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5)
- the FSM state encoding
- default latency constants
REQ-033 Result arithmetic SHALL live in one combinational sub-module, mdu_arith (inputs: op, a, b; outputs: hi_res, lo_res, div0). The FSM, counter and registers stay in mdu_ctrl.
REQ-034 The counter width SHALL be sized for max(MULT_LAT, DIV_LAT).

Verification
REQ-035 MULT, a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 DIV, a=-7 (0xFFFFFFF9), b=2 -> busy high for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIVU, a=100, b=0, after MTHI a=0x11 and MTLO a=0x22 -> busy high for 10 cycles; hi=0x11 and lo=0x22 unchanged.
REQ-038 MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF, with d_is_md=1 held -> stall_md=1 in the start cycle and the 5 busy cycles, 0 afterward; hi=0xFFFFFFFE, lo=0x00000001.
REQ-039 Start DIV, then assert reset in busy cycle 4 -> busy=0 and hi=lo=0 the next cycle; no later commit; a second start while busy (no reset) has no effect.
